// File: rtl/reg_scoreboard_pkg.sv
// Shared types for the GPR write scoreboard: register address and drain FSM state.
package reg_scoreboard_pkg;

    typedef logic [4:0] UInt5;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2,
        HOLD  = 2'd3
    } SbState;

endpackage

// File: rtl/reg_scoreboard_counter.sv
// One pending-write counter: saturating up/down with a clear that overrides both.
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_nonzero,
    output logic             o_nxt_zero
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_cnt;
    logic             w_inc;
    logic             w_dec;

    // Never wrap: up stops at max, down stops at zero.
    assign w_inc = i_inc & (r_cnt != CNT_MAX);
    assign w_dec = i_dec & (r_cnt != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (w_inc & ~w_dec) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else if (w_dec & ~w_inc) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_cnt      = r_cnt;
    assign o_nonzero  = (r_cnt != '0);
    assign o_nxt_zero = i_clr
                      | ((r_cnt == '0) & ~w_inc)
                      | ((r_cnt == CNT_W'(1)) & w_dec & ~w_inc);

endmodule

// File: rtl/reg_scoreboard.sv
// Tracks in-flight GPR writes, gates issue on unforwardable RAW hazards or saturated
// destination counters, and sequences pipeline drains for fence/CSR/trap logic.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic issue_valid,
    output logic issue_ready,
    input  UInt5 issue_rs1,
    input  UInt5 issue_rs2,
    input  UInt5 issue_rd,
    input  logic issue_wen,
    input  logic fwd_ok_rs1,
    input  logic fwd_ok_rs2,
    input  logic wb_valid,
    input  UInt5 wb_rd,
    input  logic flush,
    input  logic drain_req,
    output logic drain_done,
    output logic pending_any,
    output logic underflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]    w_cnt [NUM_REGS];
    logic [NUM_REGS-1:0] w_nonzero;
    logic [NUM_REGS-1:0] w_nxt_zero;
    logic                w_accept;
    logic                w_busy_rs1;
    logic                w_busy_rs2;
    logic                w_full;
    SbState              r_state;
    SbState              w_state_next;
    logic                r_underflow;

    // x0 is hardwired: never pending, never counted.
    assign w_cnt[0]      = '0;
    assign w_nonzero[0]  = 1'b0;
    assign w_nxt_zero[0] = 1'b1;

    assign w_accept = issue_valid & issue_ready;

    genvar gi;
    generate
        for (gi = 1; gi < NUM_REGS; gi++) begin : g_cnt
            sb_counter #(.CNT_W(CNT_W)) u_cnt (
                .clk        (clk),
                .reset      (reset),
                .i_clr      (flush),
                .i_inc      (w_accept & issue_wen & (issue_rd == UInt5'(gi))),
                .i_dec      (wb_valid & (wb_rd == UInt5'(gi))),
                .o_cnt      (w_cnt[gi]),
                .o_nonzero  (w_nonzero[gi]),
                .o_nxt_zero (w_nxt_zero[gi])
            );
        end
    endgenerate

    // Hazards read registered counters only; a retiring write still blocks this cycle.
    assign w_busy_rs1 = (issue_rs1 != '0) & (w_cnt[issue_rs1] != '0) & ~fwd_ok_rs1;
    assign w_busy_rs2 = (issue_rs2 != '0) & (w_cnt[issue_rs2] != '0) & ~fwd_ok_rs2;
    assign w_full     = issue_wen & (issue_rd != '0) & (w_cnt[issue_rd] == CNT_MAX);

    assign issue_ready = (r_state == RUN) & ~flush & ~w_busy_rs1 & ~w_busy_rs2 & ~w_full;
    assign pending_any = |w_nonzero;
    assign drain_done  = (r_state == DONE);
    assign underflow   = r_underflow;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN:     if (drain_req) w_state_next = DRAIN;
            DRAIN:   if (&w_nxt_zero) w_state_next = DONE;
            DONE:    w_state_next = drain_req ? HOLD : RUN;
            HOLD:    if (!drain_req) w_state_next = RUN;
            default: w_state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= RUN;
            r_underflow <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (wb_valid & (wb_rd != '0) & (w_cnt[wb_rd] == '0) & ~flush) begin
                r_underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard: hazards, saturation, underflow, drain FSM, reset.
module tb_reg_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic       issue_valid, issue_ready, issue_wen;
    logic [4:0] issue_rs1, issue_rs2, issue_rd, wb_rd;
    logic       fwd_ok_rs1, fwd_ok_rs2, wb_valid, flush, drain_req;
    logic       drain_done, pending_any, underflow;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    reg_scoreboard #(.NUM_REGS(32), .CNT_W(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_rs1   (issue_rs1),
        .issue_rs2   (issue_rs2),
        .issue_rd    (issue_rd),
        .issue_wen   (issue_wen),
        .fwd_ok_rs1  (fwd_ok_rs1),
        .fwd_ok_rs2  (fwd_ok_rs2),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .flush       (flush),
        .drain_req   (drain_req),
        .drain_done  (drain_done),
        .pending_any (pending_any),
        .underflow   (underflow)
    );

    task automatic idle();
        issue_valid = 0; issue_wen = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
        fwd_ok_rs1 = 0; fwd_ok_rs2 = 0; wb_valid = 0; wb_rd = 0; flush = 0; drain_req = 0;
    endtask

    // Advance to just after the next rising edge, then let new inputs settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rd, input logic wen);
        issue_valid = 1; issue_rs1 = rs1; issue_rd = rd; issue_wen = wen;
    endtask

    task automatic test_reset();
        reset = 1; idle();
        step(); #1;
        n_cmp++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got=%b exp=1", issue_ready); end
        n_cmp++; if (pending_any !== 1'b0) begin n_err++; $display("FAIL rst_pending got=%b exp=0", pending_any); end
        n_cmp++; if (drain_done !== 1'b0) begin n_err++; $display("FAIL rst_done got=%b exp=0", drain_done); end
        n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL rst_underflow got=%b exp=0", underflow); end
        reset = 0;
        step();
        $display("test_reset: checks done");
    endtask

    task automatic test_raw_stall();
        issue(0, 5, 1); #1;
        n_cmp++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL raw_first got=%b exp=1", issue_ready); end
        step(); idle(); issue(5, 0, 0); #1;
        n_cmp++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL raw_stall got=%b exp=0", issue_ready); end
        n_cmp++; if (pending_any !== 1'b1) begin n_err++; $display("FAIL raw_pending got=%b exp=1", pending_any); end
        step(); wb_valid = 1; wb_rd = 5; #1;
        n_cmp++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL raw_no_bypass got=%b exp=0", issue_ready); end
        step(); wb_valid = 0; #1;
        n_cmp++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL raw_release got=%b exp=1", issue_ready); end
        n_cmp++; if (pending_any !== 1'b0) begin n_err++; $display("FAIL raw_clear got=%b exp=0", pending_any); end
        step(); idle();
        $display("test_raw_stall: checks done");
    endtask

    task automatic test_fwd();
        issue(0, 5, 1); step();
        issue(5, 5, 1); fwd_ok_rs1 = 1; #1;
        n_cmp++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL fwd_ready got=%b exp=1", issue_ready); end
        step(); idle(); wb_valid = 1; wb_rd = 5; step();
        n_cmp++; if (pending_any !== 1'b1) begin n_err++; $display("FAIL fwd_cnt2 got=%b exp=1", pending_any); end
        step(); idle(); #1;
        n_cmp++; if (pending_any !== 1'b0) begin n_err++; $display("FAIL fwd_cnt0 got=%b exp=0", pending_any); end
        n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL fwd_underflow got=%b exp=0", underflow); end
        $display("test_fwd: checks done");
    endtask

    task automatic test_saturate();
        for (int k = 0; k < 3; k++) begin
            issue(0, 7, 1); #1;
            n_cmp++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL sat_issue%0d got=%b exp=1", k, issue_ready); end
            step();
        end
        wb_valid = 1; wb_rd = 7; #1;
        n_cmp++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL sat_full got=%b exp=0", issue_ready); end
        step(); wb_valid = 0; #1;
        n_cmp++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL sat_after_wb got=%b exp=1", issue_ready); end
        step(); idle();
        for (int k = 0; k < 3; k++) begin
            wb_valid = 1; wb_rd = 7; step();
        end
        idle(); #1;
        n_cmp++; if (pending_any !== 1'b0) begin n_err++; $display("FAIL sat_drain got=%b exp=0", pending_any); end
        n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL sat_underflow got=%b exp=0", underflow); end
        $display("test_saturate: checks done");
    endtask

    task automatic test_same_cycle();
        issue(0, 3, 1); step();
        issue(0, 3, 1); wb_valid = 1; wb_rd = 3; #1;
        n_cmp++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL same_ready got=%b exp=1", issue_ready); end
        step(); idle(); #1;
        n_cmp++; if (pending_any !== 1'b1) begin n_err++; $display("FAIL same_keep got=%b exp=1", pending_any); end
        wb_valid = 1; wb_rd = 3; step(); idle(); #1;
        n_cmp++; if (pending_any !== 1'b0) begin n_err++; $display("FAIL same_cnt1 got=%b exp=0", pending_any); end
        n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL same_underflow got=%b exp=0", underflow); end
        $display("test_same_cycle: checks done");
    endtask

    task automatic test_underflow();
        wb_valid = 1; wb_rd = 0; step(); idle(); #1;
        n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL uf_x0 got=%b exp=0", underflow); end
        wb_valid = 1; wb_rd = 9; step(); idle(); #1;
        n_cmp++; if (underflow !== 1'b1) begin n_err++; $display("FAIL uf_set got=%b exp=1", underflow); end
        wb_valid = 1; wb_rd = 0; step(); idle(); step(); #1;
        n_cmp++; if (underflow !== 1'b1) begin n_err++; $display("FAIL uf_sticky got=%b exp=1", underflow); end
        $display("test_underflow: checks done");
    endtask

    task automatic test_drain();
        issue(0, 4, 1); step(); step(); idle();
        drain_req = 1; step();
        issue(0, 0, 0); #1;
        n_cmp++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL dr_block got=%b exp=0", issue_ready); end
        wb_valid = 1; wb_rd = 4; step(); #1;
        n_cmp++; if (drain_done !== 1'b0) begin n_err++; $display("FAIL dr_early got=%b exp=0", drain_done); end
        step(); wb_valid = 0; #1;
        n_cmp++; if (drain_done !== 1'b1) begin n_err++; $display("FAIL dr_done got=%b exp=1", drain_done); end
        n_cmp++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL dr_done_block got=%b exp=0", issue_ready); end
        step(); step(); #1;
        n_cmp++; if (drain_done !== 1'b0) begin n_err++; $display("FAIL dr_pulse got=%b exp=0", drain_done); end
        n_cmp++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL dr_hold got=%b exp=0", issue_ready); end
        drain_req = 0; step(); #1;
        n_cmp++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL dr_run got=%b exp=1", issue_ready); end
        idle(); step();
        $display("test_drain: checks done");
    endtask

    task automatic test_flush_drain();
        issue(0, 6, 1); step(); idle();
        drain_req = 1; step();
        issue(0, 8, 1); flush = 1; #1;
        n_cmp++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL fl_block got=%b exp=0", issue_ready); end
        step(); idle(); #1;
        n_cmp++; if (drain_done !== 1'b1) begin n_err++; $display("FAIL fl_done got=%b exp=1", drain_done); end
        n_cmp++; if (pending_any !== 1'b0) begin n_err++; $display("FAIL fl_clear got=%b exp=0", pending_any); end
        step(); #1;
        n_cmp++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL fl_run got=%b exp=1", issue_ready); end
        // Empty drain with request dropped inside DRAIN: RUN->DRAIN->DONE->RUN.
        drain_req = 1; step(); drain_req = 0; #1;
        n_cmp++; if (drain_done !== 1'b0) begin n_err++; $display("FAIL ez_drain got=%b exp=0", drain_done); end
        step(); #1;
        n_cmp++; if (drain_done !== 1'b1) begin n_err++; $display("FAIL ez_done got=%b exp=1", drain_done); end
        step(); #1;
        n_cmp++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL ez_run got=%b exp=1", issue_ready); end
        $display("test_flush_drain: checks done");
    endtask

    task automatic test_async_reset();
        issue(0, 10, 1); step(); idle();
        drain_req = 1; step(); #1;
        n_cmp++; if (pending_any !== 1'b1) begin n_err++; $display("FAIL ar_pending got=%b exp=1", pending_any); end
        n_cmp++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL ar_drain got=%b exp=0", issue_ready); end
        #1 reset = 1;
        #1;
        n_cmp++; if (pending_any !== 1'b0) begin n_err++; $display("FAIL ar_clear got=%b exp=0", pending_any); end
        n_cmp++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL ar_run got=%b exp=1", issue_ready); end
        n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL ar_underflow got=%b exp=0", underflow); end
        n_cmp++; if (drain_done !== 1'b0) begin n_err++; $display("FAIL ar_done got=%b exp=0", drain_done); end
        #1 reset = 0; drain_req = 0;
        step();
        $display("test_async_reset: checks done");
    endtask

    initial begin
        test_reset();
        test_raw_stall();
        test_fwd();
        test_saturate();
        test_same_cycle();
        test_underflow();
        test_drain();
        test_flush_drain();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
